// File: rtl/vram_capture.sv
// Frame grabber: RGB565 + DE/VSYNC stream -> 1-bit luma threshold -> 64Kx1 VRAM write port.
// Optional CAPTURE_DITHER_EN adds a 2x2 ordered dither ahead of the threshold compare.
module vram_capture #(
    parameter int THRESHOLD = 63,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_arm,
    input  logic        i_abort,
    input  logic        i_continuous,
    input  logic [4:0]  i_r,
    input  logic [5:0]  i_g,
    input  logic [4:0]  i_b,
    input  logic        i_vsync,
    input  logic        i_de,
    output logic [15:0] o_addr,
    output logic        o_dat,
    output logic        o_we,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_r;
    logic [5:0]  r_g;
    logic [4:0]  r_b;
    logic        r_de1;
    logic        r_de2;
    logic        r_vs1;
    logic        r_vs2;
    logic [8:0]  r_x;
    logic [8:0]  r_y;

    logic        w_vs_edge;
    logic        w_de_fall;
    logic        w_accept;
    logic        w_frame_end;
    logic [6:0]  w_luma;
    logic        w_bit;

    // Stage 1: input registers plus one-deep history for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_r   <= '0;
            r_g   <= '0;
            r_b   <= '0;
            r_de1 <= 1'b0;
            r_de2 <= 1'b0;
            r_vs1 <= ~VSYNC_POL;
            r_vs2 <= ~VSYNC_POL;
        end else begin
            r_r   <= i_r;
            r_g   <= i_g;
            r_b   <= i_b;
            r_de1 <= i_de;
            r_de2 <= r_de1;
            r_vs1 <= i_vsync;
            r_vs2 <= r_vs1;
        end
    end

    assign w_vs_edge = (r_vs1 == VSYNC_POL) && (r_vs2 != VSYNC_POL);
    assign w_de_fall = r_de2 && !r_de1;
    assign w_luma    = {2'b00, r_r} + {1'b0, r_g} + {2'b00, r_b};

`ifdef CAPTURE_DITHER_EN
    localparam logic [7:0] C_THR_D = 8'(THRESHOLD + 12);
    logic [7:0] w_dith;

    always_comb begin
        w_dith = 8'd0;
        case ({r_x[1], r_y[0]})
            2'b00:   w_dith = 8'd0;
            2'b10:   w_dith = 8'd16;
            2'b01:   w_dith = 8'd24;
            default: w_dith = 8'd8;
        endcase
    end

    assign w_bit = ({1'b0, w_luma} + w_dith) > C_THR_D;
`else
    localparam logic [6:0] C_THR = 7'(THRESHOLD);
    assign w_bit = w_luma > C_THR;
`endif

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state; abort dominates every other request
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (i_arm)     w_next = S_WAIT_VS;
                S_WAIT_VS: if (w_vs_edge) w_next = S_CAPTURE;
                S_CAPTURE: if (w_vs_edge && !i_continuous) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        w_frame_end = (r_state == S_CAPTURE) && w_vs_edge && !i_abort;
        w_accept    = (r_state == S_CAPTURE) && !i_abort && r_de1 && !r_x[0] && !r_y[8];
    end

    // Pixel position; a new frame restarts at the origin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_vs_edge) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_de1) begin
            r_x <= r_x + 9'd1;
        end else if (w_de_fall) begin
            r_x <= '0;
            if (r_y != 9'd511) r_y <= r_y + 9'd1;
        end
    end

    // Output register; address and data hold while no write is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_dat       <= 1'b0;
            o_done      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_we   <= w_accept;
            o_done <= w_frame_end;
            if (w_accept) begin
                o_addr <= {r_y[7:0], r_x[8:1]};
                o_dat  <= w_bit;
            end
            if (w_frame_end) o_frame_cnt <= o_frame_cnt + 8'd1;
        end
    end

endmodule
